// File: rtl/fft_stream_ctrl.sv
// ---------------------------------------------------------------------------
// fft_stream_ctrl
//
// Frame sequencer sitting between a valid/ready sample source and a
// free-running N-point streaming FFT pipeline that has no stall input.
// Frames are only started on the pipeline's phase 0, so every frame lands
// exactly on one transform block. Source samples that are missing inside a
// frame are replaced by zero and the frame is flagged. Pipeline outputs are
// tagged with valid / natural-order bin index / last / error, and the module
// keeps frame and underrun counters.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset (shared with FFT)
//   en                   allow new frames to start
//   s_valid, s_ready     source handshake (accept on s_valid && s_ready)
//   s_r, s_i             signed source sample
//   fft_x_r, fft_x_i     pipeline input (combinational, zero when not feeding)
//   fft_X_r, fft_X_i     pipeline output
//   m_valid              output bin valid (no backpressure)
//   m_r, m_i             registered pipeline output
//   m_index              natural-order bin number of the current output
//   m_last               final bin of a frame
//   m_err                frame contained zero-filled samples
//   busy                 frame being fed or still in flight
//   frame_cnt            completed output frames (wraps)
//   underrun_cnt         zero-filled samples (saturates at 255)
// ---------------------------------------------------------------------------
module fft_stream_ctrl #(
    parameter int N    = 8,
    parameter int LOGN = 3,
    parameter int DW   = 12,
    parameter int LAT  = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [DW-1:0] s_r,
    input  logic signed [DW-1:0] s_i,
    output logic signed [DW-1:0] fft_x_r,
    output logic signed [DW-1:0] fft_x_i,
    input  logic signed [DW-1:0] fft_X_r,
    input  logic signed [DW-1:0] fft_X_i,
    output logic                 m_valid,
    output logic signed [DW-1:0] m_r,
    output logic signed [DW-1:0] m_i,
    output logic [LOGN-1:0]      m_index,
    output logic                 m_last,
    output logic                 m_err,
    output logic                 busy,
    output logic [15:0]          frame_cnt,
    output logic [7:0]           underrun_cnt
);

    localparam logic [LOGN-1:0] PH_LAST = LOGN'(N - 1);

    // The err hand-off below assumes a frame's flag is known by the time its
    // first bin leaves the pipeline and that at most two frames overlap.
    generate
        if ((LAT < N - 1) || (LAT > 2 * N - 2)) begin : g_bad_lat
            $error("fft_stream_ctrl: LAT must lie in [N-1, 2N-2]");
        end
        if ((1 << LOGN) != N) begin : g_bad_logn
            $error("fft_stream_ctrl: N must equal 2**LOGN");
        end
    endgenerate

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [LOGN-1:0] phase_q;
    logic            last_phase;
    logic            run;
    logic            frame_end;     // RUN cycle at phase N-1
    logic            starve;        // RUN cycle without a source sample
    logic            uf_q;          // underrun seen earlier in current frame
    logic            frame_err_now; // underrun flag including this cycle

    // -----------------------------------------------------------------------
    // Phase counter: mirrors the pipeline's internal stage counters, which
    // restart from the same reset.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_q + LOGN'(1);
        end
    end

    assign last_phase = (phase_q == PH_LAST);
    assign run        = (state_q == ST_RUN);

    // -----------------------------------------------------------------------
    // Frame FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        s_ready   = 1'b0;
        fft_x_r   = '0;
        fft_x_i   = '0;
        frame_end = 1'b0;
        starve    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Start one cycle early so the first sample hits phase 0.
                if (en && s_valid && last_phase) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    fft_x_r = s_r;
                    fft_x_i = s_i;
                end else begin
                    starve = 1'b1;
                end
                if (last_phase) begin
                    frame_end = 1'b1;
                    if (!(en && s_valid)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            uf_q <= 1'b0;
        end else if (frame_end) begin
            uf_q <= 1'b0;
        end else if (starve) begin
            uf_q <= 1'b1;
        end
    end

    assign frame_err_now = uf_q | starve;

    // -----------------------------------------------------------------------
    // Tag delay line: {active, phase} travels alongside the data through the
    // pipeline so the output side knows which beats belong to a frame.
    // -----------------------------------------------------------------------
    logic [LAT-1:0]  act_vec;
    logic            tag_act;
    logic [LOGN-1:0] tag_ph;
    logic [LOGN-1:0] tag_idx;
    logic            tag_last;

    generate
        for (genvar gi = 0; gi < LAT; gi++) begin : g_dl
            logic            act_q;
            logic [LOGN-1:0] ph_q;
            logic            act_in;
            logic [LOGN-1:0] ph_in;

            if (gi == 0) begin : g_head
                assign act_in = run;
                assign ph_in  = phase_q;
            end else begin : g_link
                assign act_in = g_dl[gi-1].act_q;
                assign ph_in  = g_dl[gi-1].ph_q;
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    act_q <= 1'b0;
                    ph_q  <= '0;
                end else begin
                    act_q <= act_in;
                    ph_q  <= ph_in;
                end
            end

            assign act_vec[gi] = act_q;
        end

        // Pipeline emits bins in bit-reversed order.
        for (genvar gi = 0; gi < LOGN; gi++) begin : g_rev
            assign tag_idx[gi] = tag_ph[LOGN-1-gi];
        end
    endgenerate

    assign tag_act  = g_dl[LAT-1].act_q;
    assign tag_ph   = g_dl[LAT-1].ph_q;
    assign tag_last = tag_act && (tag_ph == PH_LAST);

    // -----------------------------------------------------------------------
    // Per-frame error flags. A frame's flag is pushed when its feed ends and
    // popped after its last bin. When LAT == N-1 the first bin leaves in the
    // very cycle the feed ends, so an empty queue bypasses the live flag.
    // -----------------------------------------------------------------------
    logic [1:0] err_fifo_q;
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] err_cnt_q;
    logic       err_out;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_fifo_q <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            if (frame_end) begin
                err_fifo_q[wr_ptr_q] <= frame_err_now;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (tag_last) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({frame_end, tag_last})
                2'b10:   err_cnt_q <= err_cnt_q + 2'd1;
                2'b01:   err_cnt_q <= err_cnt_q - 2'd1;
                default: err_cnt_q <= err_cnt_q;
            endcase
        end
    end

    assign err_out = (err_cnt_q != 2'd0) ? err_fifo_q[rd_ptr_q] : frame_err_now;

    // -----------------------------------------------------------------------
    // Output registers and counters
    // -----------------------------------------------------------------------
    logic                 m_valid_q, m_last_q, m_err_q;
    logic signed [DW-1:0] m_r_q, m_i_q;
    logic [LOGN-1:0]      m_index_q;
    logic [15:0]          frame_cnt_q;
    logic [7:0]           underrun_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid_q      <= 1'b0;
            m_last_q       <= 1'b0;
            m_err_q        <= 1'b0;
            m_r_q          <= '0;
            m_i_q          <= '0;
            m_index_q      <= '0;
            frame_cnt_q    <= '0;
            underrun_cnt_q <= '0;
        end else begin
            m_valid_q <= tag_act;
            m_last_q  <= tag_last;
            m_err_q   <= tag_act && err_out;
            m_r_q     <= fft_X_r;
            m_i_q     <= fft_X_i;
            m_index_q <= tag_idx;
            if (tag_last) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (starve && (underrun_cnt_q != 8'hFF)) begin
                underrun_cnt_q <= underrun_cnt_q + 8'd1;
            end
        end
    end

    assign m_valid      = m_valid_q;
    assign m_last       = m_last_q;
    assign m_err        = m_err_q;
    assign m_r          = m_r_q;
    assign m_i          = m_i_q;
    assign m_index      = m_index_q;
    assign frame_cnt    = frame_cnt_q;
    assign underrun_cnt = underrun_cnt_q;
    assign busy         = run || (|act_vec);

endmodule

// File: tb/tb_fft_stream_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fft_stream_ctrl
//
// Directed stimulus sequence with randomized sample data. A behavioural
// reference (frame rules in terms of phase blocks plus a floating-point DFT
// standing in for the FFT pipeline) predicts every output cycle by cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fft_stream_ctrl;

    localparam int N    = 8;
    localparam int LOGN = 3;
    localparam int DW   = 12;
    localparam int LAT  = 7;

    logic                 clk = 1'b0;
    logic                 rst_n, en, s_valid, s_ready;
    logic signed [DW-1:0] s_r, s_i, fft_x_r, fft_x_i, m_r, m_i;
    logic signed [DW-1:0] fft_X_r = '0;
    logic signed [DW-1:0] fft_X_i = '0;
    logic                 m_valid, m_last, m_err, busy;
    logic [LOGN-1:0]      m_index;
    logic [15:0]          frame_cnt;
    logic [7:0]           underrun_cnt;

    always #5 clk = ~clk;

    fft_stream_ctrl #(.N(N), .LOGN(LOGN), .DW(DW), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .s_valid(s_valid), .s_ready(s_ready),
        .s_r(s_r), .s_i(s_i), .fft_x_r(fft_x_r), .fft_x_i(fft_x_i),
        .fft_X_r(fft_X_r), .fft_X_i(fft_X_i), .m_valid(m_valid), .m_r(m_r),
        .m_i(m_i), .m_index(m_index), .m_last(m_last), .m_err(m_err),
        .busy(busy), .frame_cnt(frame_cnt), .underrun_cnt(underrun_cnt)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    typedef struct {
        int idx;
        bit last;
        bit err;
    } beat_t;

    beat_t       beats[int];       // expected output beats keyed by cycle
    int          cyc = 0;          // cycles since reset; phase = cyc % N
    bit          model_ok = 1'b0;
    bit          in_frame, frame_next, frame_uf;
    int          uf_count;
    logic [15:0] fcnt;
    int          blk_r[N], blk_i[N];
    int          xr_ring[4][N], xi_ring[4][N];
    int          exp_mr, exp_mi;
    int          dc_r;
    int          first_beat_cyc;

    function automatic int bitrev(input int p);
        return ((p & 1) << 2) | (p & 2) | ((p >> 2) & 1);
    endfunction

    function automatic int rnd(input real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(-v + 0.5);
    endfunction

    task automatic do_dft(input int slot);
        for (int k = 0; k < N; k++) begin
            real sr, si, a;
            sr = 0.0;
            si = 0.0;
            for (int n = 0; n < N; n++) begin
                a  = -2.0 * 3.14159265358979 * real'(k * n) / real'(N);
                sr = sr + real'(blk_r[n]) * $cos(a) - real'(blk_i[n]) * $sin(a);
                si = si + real'(blk_r[n]) * $sin(a) + real'(blk_i[n]) * $cos(a);
            end
            xr_ring[slot][k] = rnd(sr);
            xi_ring[slot][k] = rnd(si);
        end
    endtask

    task automatic model_reset();
        in_frame       = 1'b0;
        frame_next     = 1'b0;
        frame_uf       = 1'b0;
        uf_count       = 0;
        fcnt           = '0;
        exp_mr         = 0;
        exp_mi         = 0;
        first_beat_cyc = -1;
        beats.delete();
        cyc            = 0;
    endtask

    // Per-cycle model + checks, evaluated mid-cycle on the falling edge.
    always @(negedge clk) begin : model
        int    ph, q, xr, xi;
        bit    exp_busy;
        beat_t b;
        if (model_ok) begin
            ph = cyc % N;
            if (ph == 0) begin
                in_frame   = frame_next;
                frame_next = 1'b0;
                frame_uf   = 1'b0;
            end
            if (beats.exists(cyc) && beats[cyc].last) fcnt = fcnt + 16'd1;

            chk("s_ready", 32'(s_ready), 32'(in_frame));
            xr = (in_frame && s_valid) ? int'(s_r) : 0;
            xi = (in_frame && s_valid) ? int'(s_i) : 0;
            chk("fft_x_r", 32'(fft_x_r), xr);
            chk("fft_x_i", 32'(fft_x_i), xi);
            if (beats.exists(cyc)) begin
                b = beats[cyc];
                chk("m_valid", 32'(m_valid), 1);
                chk("m_index", 32'(m_index), b.idx);
                chk("m_last", 32'(m_last), 32'(b.last));
                chk("m_err", 32'(m_err), 32'(b.err));
                if (b.idx == 0) dc_r = int'(m_r);
                beats.delete(cyc);
            end else begin
                chk("m_valid_idle", 32'(m_valid), 0);
                chk("m_last_idle", 32'(m_last), 0);
                chk("m_err_idle", 32'(m_err), 0);
            end
            if (m_valid === 1'b1 && first_beat_cyc < 0) first_beat_cyc = cyc;
            chk("m_r", 32'(m_r), exp_mr);
            chk("m_i", 32'(m_i), exp_mi);
            exp_busy = in_frame;
            for (int d = 1; d <= LAT; d++) if (beats.exists(cyc + d)) exp_busy = 1'b1;
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("frame_cnt", 32'(frame_cnt), 32'(fcnt));
            chk("underrun_cnt", 32'(underrun_cnt), uf_count);

            // advance the reference with this cycle's inputs
            blk_r[ph] = xr;
            blk_i[ph] = xi;
            if (in_frame && !s_valid) begin
                if (uf_count < 255) uf_count++;
                frame_uf = 1'b1;
            end
            if (ph == N - 1) begin
                do_dft((cyc / N) % 4);
                if (in_frame) begin
                    for (int p = 0; p < N; p++) begin
                        b.idx  = bitrev(p);
                        b.last = (p == N - 1);
                        b.err  = frame_uf;
                        beats[cyc - (N - 1) + LAT + 1 + p] = b;
                    end
                end
                frame_next = (en === 1'b1) && (s_valid === 1'b1);
            end

            // stand-in FFT pipeline: block b, position p appears at 8b+LAT+p
            q = cyc - LAT;
            if (q < 0) begin
                fft_X_r = '0;
                fft_X_i = '0;
            end else begin
                fft_X_r = DW'(xr_ring[(q / N) % 4][bitrev(q % N)]);
                fft_X_i = DW'(xi_ring[(q / N) % 4][bitrev(q % N)]);
            end
            exp_mr = int'(fft_X_r);
            exp_mi = int'(fft_X_i);
        end else begin
            fft_X_r = '0;
            fft_X_i = '0;
        end

        if (rst_n === 1'b0) begin
            model_reset();
            model_ok = 1'b1;
        end else if (model_ok) begin
            cyc++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        en      = 1'b0;
        s_valid = 1'b0;
        repeat (n) next_cycle();
    endtask

    // mode: 0 random data, 1 impulse, 2 ramp.
    // gaps: 0 none, 1 phases 2 and 5 of the first frame, 2 random (never at N-1).
    task automatic run_frames(input int nframes, input int mode, input int drop_ph, input int gaps);
        int fidx, guard, ph, v;
        bit done;
        fidx  = 0;
        guard = 0;
        done  = 1'b0;
        while (!done) begin
            ph = cyc % N;
            if (s_ready && ph == 0) fidx++;
            en      = !(fidx == nframes && ph >= drop_ph);
            s_valid = 1'b1;
            if (gaps == 1 && fidx == 1 && (ph == 2 || ph == 5)) s_valid = 1'b0;
            if (gaps == 2 && fidx >= 1 && ph != N - 1 && $urandom_range(0, 4) == 0) s_valid = 1'b0;
            case (mode)
                1:       begin s_r = (ph == 0) ? 12'sd256 : 12'sd0; s_i = '0; end
                2:       begin s_r = DW'(ph); s_i = '0; end
                default: begin
                    v   = int'($urandom_range(0, 200)) - 100;
                    s_r = DW'(v);
                    v   = int'($urandom_range(0, 200)) - 100;
                    s_i = DW'(v);
                end
            endcase
            if (fidx == nframes && ph == N - 1) done = 1'b1;
            guard++;
            if (guard > 40 * nframes + 40) done = 1'b1;
            next_cycle();
        end
        chk("frames_started", fidx, nframes);
        en      = 1'b0;
        s_valid = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin : stim
        int g;
        rst_n   = 1'b0;
        en      = 1'b0;
        s_valid = 1'b0;
        s_r     = '0;
        s_i     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ramp frame straight out of reset
        run_frames(1, 2, N - 1, 0);
        idle(12);
        chk("t1_first_valid_cycle", first_beat_cyc, 16);
        chk("t1_dc_bin", dc_r, 28);
        chk("t1_frame_cnt", 32'(frame_cnt), 1);

        // three back-to-back impulse frames
        run_frames(3, 1, N - 1, 0);
        idle(18);
        chk("t3_frame_cnt", 32'(frame_cnt), 4);
        chk("t3_busy_after", 32'(busy), 0);

        // source valid first seen at phase 3
        g = 0;
        while ((cyc % N) != 3 && g < 2 * N) begin
            next_cycle();
            g++;
        end
        run_frames(1, 0, N - 1, 0);
        idle(18);

        // two frames, gaps at phases 2 and 5 of the first
        run_frames(2, 0, N - 1, 1);
        idle(18);
        chk("t4_underrun_cnt", 32'(underrun_cnt), 2);

        // en dropped at phase 4 of the frame
        run_frames(1, 0, 4, 0);
        idle(18);
        chk("t5_frame_cnt", 32'(frame_cnt), 8);

        // reset while bins are coming out
        run_frames(1, 0, N - 1, 0);
        g = 0;
        while (m_valid !== 1'b1 && g < 20) begin
            next_cycle();
            g++;
        end
        chk("t6_valid_before_reset", 32'(m_valid), 1);
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        chk("t6_rst_m_valid", 32'(m_valid), 0);
        chk("t6_rst_frame_cnt", 32'(frame_cnt), 0);
        chk("t6_rst_underrun_cnt", 32'(underrun_cnt), 0);
        chk("t6_rst_s_ready", 32'(s_ready), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        run_frames(1, 2, N - 1, 0);
        idle(18);
        chk("t6_frame_cnt", 32'(frame_cnt), 1);
        chk("t6_dc_bin", dc_r, 28);

        // random bursts with random gaps
        repeat (3) begin
            run_frames(int'($urandom_range(1, 3)), 0, N - 1, 2);
            idle(int'($urandom_range(0, 5)));
        end
        idle(20);
        chk("t7_busy_after", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
